// File: rtl/uart_word_loader.sv
// uart_word_loader
// Receives 8N1 UART bytes, packs them little-endian into 32-bit words and
// writes each word to consecutive memory addresses. Loading ends on an
// END_WORD marker (not written) or after the last address is written.
//
// Ports:
//   wb_clk_i     - clock
//   wb_rst_i     - synchronous active-high reset
//   en_i         - loading enable; low holds the receiver idle / aborts a frame
//   rx_i         - asynchronous UART serial input (idles high)
//   mem_we_o     - one-cycle memory write strobe
//   mem_addr_o   - word address of the current write
//   mem_wdata_o  - assembled word
//   done_o       - sticky, loading complete
//   frame_err_o  - sticky, a stop-bit error was seen
//   word_cnt_o   - number of words written so far
module uart_word_loader #(
    parameter int unsigned CLKS_PER_BIT = 347,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned WCNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state, state_n;
    logic               rx_q1, rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               byte_valid;
    logic [1:0]         byte_idx;
    logic [23:0]        word;
    logic               cnt_clr_c;
    logic               bit_smp_c;
    logic               stop_ok_c;
    logic               stop_bad_c;
    logic               abort_c;
    logic [31:0]        full_word_c;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx_i;
            rx_s  <= rx_q1;
        end
    end

    // RX FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // RX FSM next state and sample strobes.
    always_comb begin
        state_n    = state;
        cnt_clr_c  = 1'b0;
        bit_smp_c  = 1'b0;
        stop_ok_c  = 1'b0;
        stop_bad_c = 1'b0;
        abort_c    = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_clr_c = 1'b1;
                if (!rx_s && en_i && !done_o) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr_c = 1'b1;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_clr_c = 1'b1;
                    bit_smp_c = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_clr_c  = 1'b1;
                    state_n    = S_IDLE;
                    stop_ok_c  = rx_s;
                    stop_bad_c = !rx_s;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Disable or completion kills any frame in flight.
        if (state != S_IDLE && (!en_i || done_o)) begin
            state_n    = S_IDLE;
            cnt_clr_c  = 1'b1;
            bit_smp_c  = 1'b0;
            stop_ok_c  = 1'b0;
            stop_bad_c = 1'b0;
            abort_c    = 1'b1;
        end
    end

    // Bit timing counter, data shift register and byte-valid strobe.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= stop_ok_c;
            cnt        <= cnt_clr_c ? '0 : cnt + CNT_W'(1);
            if (state == S_IDLE) begin
                bit_idx <= '0;
            end else if (bit_smp_c) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (bit_smp_c) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // The fourth byte is merged directly, so only the lower three bytes are held.
    assign full_word_c = {shreg, word};

    // Word assembly, memory write and status flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
            word_cnt_o  <= '0;
            byte_idx    <= '0;
            word        <= '0;
        end else begin
            mem_we_o <= 1'b0;

            // Address advances after the strobe; it parks on the last address.
            if (mem_we_o) begin
                word_cnt_o <= word_cnt_o + WCNT_W'(1);
                if (mem_addr_o != ADDR_MAX) begin
                    mem_addr_o <= mem_addr_o + ADDR_W'(1);
                end
            end

            if (stop_bad_c) begin
                frame_err_o <= 1'b1;
                byte_idx    <= '0;
                word        <= '0;
            end else if (abort_c) begin
                byte_idx <= '0;
                word     <= '0;
            end else if (byte_valid && !done_o) begin
                if (byte_idx == 2'd3) begin
                    byte_idx <= '0;
                    word     <= '0;
                    if (full_word_c == END_WORD) begin
                        done_o <= 1'b1;
                    end else begin
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= full_word_c;
                        if (mem_addr_o == ADDR_MAX) begin
                            done_o <= 1'b1;
                        end
                    end
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word[7:0]   <= shreg;
                        2'd1:    word[15:8]  <= shreg;
                        default: word[23:16] <= shreg;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: a 1 KiW instance and a 4-word instance driven by
// a UART byte generator; captured writes are compared against a word-list model.
module tb_uart_word_loader;

    localparam int unsigned CPB  = 16;
    localparam logic [31:0] ENDW = 32'h0000_0FFF;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, en, rx_a, rx_b;
    logic        we_a, done_a, ferr_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] wcnt_a;
    logic        we_b, done_b, ferr_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wcnt_b;

    wr_t         wq_a[$];
    wr_t         wq_b[$];
    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10), .END_WORD(ENDW)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .rx_i(rx_a),
        .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .done_o(done_a), .frame_err_o(ferr_a), .word_cnt_o(wcnt_a)
    );

    uart_word_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .END_WORD(ENDW)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .rx_i(rx_b),
        .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .done_o(done_b), .frame_err_o(ferr_b), .word_cnt_o(wcnt_b)
    );

    // Capture every write strobe, together with done as seen in that cycle.
    always @(negedge clk) begin
        wr_t r;
        if (we_a === 1'b1) begin
            r.addr = addr_a; r.data = wdata_a; r.done = done_a;
            wq_a.push_back(r);
        end
        if (we_b === 1'b1) begin
            r.addr = {8'b0, addr_b}; r.data = wdata_b; r.done = done_b;
            wq_b.push_back(r);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit);
        set_rx(sel, 1'b0);
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            cycles(CPB);
        end
        set_rx(sel, stop_bit);
        cycles(CPB);
        set_rx(sel, 1'b1);
        cycles(CPB + int'($urandom_range(0, 4)));
    endtask

    task automatic send_word(input int sel, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        cycles(3);
        rst = 1'b0;
        wq_a.delete();
        wq_b.delete();
        cycles(2);
    endtask

    // Expected writes: words in order at addresses 0.., stopping at the end
    // marker or once capacity is used; done is seen with the last-address write.
    task automatic build_expected(input int cap);
        int n = 0;
        wr_t r;
        exp_q.delete();
        foreach (words[i]) begin
            if (words[i] == ENDW) break;
            r.addr = 10'(n); r.data = words[i]; r.done = (n == cap - 1);
            exp_q.push_back(r);
            n++;
            if (n == cap) break;
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == ENDW) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        n_tests++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we_a); end
        n_tests++; if (addr_a !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
        n_tests++; if (wdata_a !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_tests++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr_a); end
        n_tests++; if (wcnt_a !== 11'd0) begin n_fail++; $display("FAIL reset_wcnt: got %0d want 0", wcnt_a); end
        n_tests++;
        if ({we_b, addr_b, wdata_b, done_b, ferr_b, wcnt_b} !== 40'd0) begin
            n_fail++; $display("FAIL reset_b: got %h want 0", {we_b, addr_b, wdata_b, done_b, ferr_b, wcnt_b});
        end
    endtask

    task automatic test_single_word();
        do_reset();
        send_byte(0, 8'h69, 1'b1);
        send_byte(0, 8'hAF, 1'b1);
        send_byte(0, 8'h1F, 1'b1);
        send_byte(0, 8'h42, 1'b1);
        cycles(4);
        n_tests++; if (wq_a.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", wq_a.size()); end
        if (wq_a.size() >= 1) begin
            n_tests++; if (wq_a[0].addr !== 10'd0) begin n_fail++; $display("FAIL single_addr: got %0d want 0", wq_a[0].addr); end
            n_tests++; if (wq_a[0].data !== 32'h421FAF69) begin n_fail++; $display("FAIL single_data: got %h want 421faf69", wq_a[0].data); end
        end
        n_tests++; if (wcnt_a !== 11'd1) begin n_fail++; $display("FAIL single_wcnt: got %0d want 1", wcnt_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b want 0", done_a); end
    endtask

    task automatic test_end_marker();
        do_reset();
        send_word(0, 32'h421FAF69);
        send_word(0, 32'hC05FDF3C);
        send_word(0, ENDW);
        cycles(4);
        n_tests++; if (wq_a.size() != 2) begin n_fail++; $display("FAIL end_count: got %0d want 2", wq_a.size()); end
        if (wq_a.size() >= 2) begin
            n_tests++;
            if (wq_a[0].addr !== 10'd0 || wq_a[0].data !== 32'h421FAF69 || wq_a[1].addr !== 10'd1 || wq_a[1].data !== 32'hC05FDF3C) begin
                n_fail++; $display("FAIL end_writes: got %0d:%h %0d:%h want 0:421faf69 1:c05fdf3c", wq_a[0].addr, wq_a[0].data, wq_a[1].addr, wq_a[1].data);
            end
        end
        n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL end_done: got %b want 1", done_a); end
        n_tests++; if (wcnt_a !== 11'd2) begin n_fail++; $display("FAIL end_wcnt: got %0d want 2", wcnt_a); end
        send_word(0, rand_word());
        cycles(4);
        n_tests++; if (wq_a.size() != 2) begin n_fail++; $display("FAIL end_ignore: got %0d writes want 2", wq_a.size()); end
        n_tests++; if (addr_a !== 10'd2) begin n_fail++; $display("FAIL end_addr: got %0d want 2", addr_a); end
    endtask

    task automatic test_glitch();
        do_reset();
        rx_a = 1'b0;
        cycles(4);
        rx_a = 1'b1;
        cycles(3 * CPB);
        n_tests++; if (wq_a.size() != 0) begin n_fail++; $display("FAIL glitch_write: got %0d writes want 0", wq_a.size()); end
        n_tests++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b want 0", ferr_a); end
        send_word(0, 32'hC05FDF3C);
        cycles(4);
        n_tests++;
        if (wq_a.size() != 1 || wq_a[0].data !== 32'hC05FDF3C || wq_a[0].addr !== 10'd0) begin
            n_fail++; $display("FAIL glitch_recover: got %0d writes want 1 of c05fdf3c at 0", wq_a.size());
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_byte(0, 8'h69, 1'b1);
        send_byte(0, 8'($urandom), 1'b0);
        send_word(0, 32'h421FAF69);
        cycles(4);
        n_tests++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", ferr_a); end
        n_tests++; if (wq_a.size() != 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", wq_a.size()); end
        if (wq_a.size() >= 1) begin
            n_tests++;
            if (wq_a[0].data !== 32'h421FAF69 || wq_a[0].addr !== 10'd0) begin
                n_fail++; $display("FAIL ferr_write: got %0d:%h want 0:421faf69", wq_a[0].addr, wq_a[0].data);
            end
        end
    endtask

    task automatic test_en_abort();
        logic [31:0] w1, w2;
        w1 = rand_word();
        w2 = rand_word();
        do_reset();
        send_word(0, w1);
        send_byte(0, 8'h11, 1'b1);
        rx_a = 1'b0;
        cycles(3 * CPB);
        en = 1'b0;
        cycles(2);
        rx_a = 1'b1;
        cycles(CPB);
        en = 1'b1;
        cycles(CPB);
        send_word(0, w2);
        cycles(4);
        n_tests++; if (wq_a.size() != 2) begin n_fail++; $display("FAIL abort_count: got %0d want 2", wq_a.size()); end
        if (wq_a.size() >= 2) begin
            n_tests++;
            if (wq_a[1].addr !== 10'd1 || wq_a[1].data !== w2) begin
                n_fail++; $display("FAIL abort_write: got %0d:%h want 1:%h", wq_a[1].addr, wq_a[1].data, w2);
            end
        end
        n_tests++; if (wcnt_a !== 11'd2 || ferr_a !== 1'b0) begin n_fail++; $display("FAIL abort_status: got wcnt %0d ferr %b want 2 0", wcnt_a, ferr_a); end
    endtask

    task automatic test_full_mem();
        do_reset();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(rand_word());
        build_expected(4);
        foreach (words[i]) send_word(1, words[i]);
        cycles(4);
        n_tests++; if (wq_b.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d want %0d", wq_b.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wq_b.size(); i++) begin
            n_tests++;
            if (wq_b[i].addr !== exp_q[i].addr || wq_b[i].data !== exp_q[i].data || wq_b[i].done !== exp_q[i].done) begin
                n_fail++; $display("FAIL full_write%0d: got %0d:%h done %b want %0d:%h done %b", i,
                    wq_b[i].addr, wq_b[i].data, wq_b[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
            end
        end
        n_tests++; if (wcnt_b !== 3'd4) begin n_fail++; $display("FAIL full_wcnt: got %0d want 4", wcnt_b); end
        n_tests++; if (done_b !== 1'b1 || addr_b !== 2'd3) begin n_fail++; $display("FAIL full_done: got done %b addr %0d want 1 3", done_b, addr_b); end
    endtask

    task automatic test_random();
        do_reset();
        words.delete();
        for (int i = 0; i < 6; i++) words.push_back(rand_word());
        words.push_back(ENDW);
        words.push_back(rand_word());
        build_expected(1024);
        foreach (words[i]) send_word(0, words[i]);
        cycles(4);
        n_tests++; if (wq_a.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", wq_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wq_a.size(); i++) begin
            n_tests++;
            if (wq_a[i].addr !== exp_q[i].addr || wq_a[i].data !== exp_q[i].data) begin
                n_fail++; $display("FAIL rand_write%0d: got %0d:%h want %0d:%h", i, wq_a[i].addr, wq_a[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_tests++; if (done_a !== 1'b1 || wcnt_a !== 11'(exp_q.size())) begin n_fail++; $display("FAIL rand_status: got done %b wcnt %0d want 1 %0d", done_a, wcnt_a, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(0, rand_word());
        send_byte(0, 8'h11, 1'b1);
        send_byte(0, 8'h22, 1'b1);
        rx_a = 1'b0;
        cycles(3 * CPB);
        rst  = 1'b1;
        rx_a = 1'b1;
        cycles(1);
        rst = 1'b0;
        n_tests++;
        if ({we_a, addr_a, wdata_a, done_a, ferr_a, wcnt_a} !== 56'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h want 0", {we_a, addr_a, wdata_a, done_a, ferr_a, wcnt_a});
        end
        wq_a.delete();
        cycles(CPB);
        send_word(0, 32'h421FAF69);
        cycles(4);
        n_tests++;
        if (wq_a.size() != 1 || wq_a[0].addr !== 10'd0 || wq_a[0].data !== 32'h421FAF69) begin
            n_fail++; $display("FAIL midrst_write: got %0d writes want 1 of 421faf69 at 0", wq_a.size());
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        test_reset();
        test_single_word();
        test_end_marker();
        test_glitch();
        test_frame_err();
        test_en_abort();
        test_full_mem();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Serial program loader for the single-precision FPU user project. It receives 8N1 UART bytes on the programming pin (mprj_io[5]) and packs them little-endian into 32-bit words. Each word is written to the instruction/operand memory at consecutive addresses. Loading stops on an end-marker word or when memory is full, and `done_o` then releases the core, which raises the ready pin (mprj_io[37]) and starts driving results.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 347: clock cycles per UART bit (40 MHz / 115200). Must be ≥ 4.
- `ADDR_W`, default 10: memory word-address width.
- `END_WORD`, default 32'h0000_0FFF: terminating word. It is not written to memory.

Ports:
- `wb_clk_i`, input, 1: sole clock.
- `wb_rst_i`, input, 1: synchronous, active-high reset.
- `en_i`, input, 1: loading enable. While low, the receiver is held idle.
- `rx_i`, input, 1: asynchronous UART serial input; idles high.
- `mem_we_o`, output, 1: one-cycle write strobe.
- `mem_addr_o`, output, ADDR_W: word address of the current write.
- `mem_wdata_o`, output, 32: assembled word.
- `done_o`, output, 1: sticky; loading complete.
- `frame_err_o`, output, 1: sticky; at least one stop-bit error seen.
- `word_cnt_o`, output, ADDR_W+1: number of words written so far.

## Operation

- Input synchronizer: two-flop synchronizer on `rx_i`, giving `rx_s`. All decisions use `rx_s`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a counter is cleared. The FSM leaves IDLE when `rx_s` is 0 and `en_i` = 1 and `done_o` = 0, and goes to START.
  - START: counts to CLKS_PER_BIT/2 (integer division), then samples. If `rx_s` = 0, go to DATA with the counter cleared. If `rx_s` = 1, treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After 8 bits go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If `rx_s` = 1, pulse an internal byte-valid strobe for one cycle. If `rx_s` = 0, set `frame_err_o`, discard the byte, and clear the byte index and partial word. In both cases return to IDLE.
- Word assembler:
  - A 2-bit byte index places each byte little-endian: byte 0 goes to [7:0] and byte 3 goes to [31:24].
  - On the 4th byte, if the word equals END_WORD, set `done_o` and do not write.
  - Otherwise, on the next cycle drive `mem_we_o` = 1 with `mem_addr_o` = current address and `mem_wdata_o` = the word. The address and `word_cnt_o` then increment.
  - After the write to address 2^ADDR_W−1, set `done_o`. The address does not wrap.
- Once `done_o` = 1, `rx_i` is ignored entirely and no further writes occur.
- Dropping `en_i` mid-frame aborts the frame immediately: the FSM goes to IDLE, and the byte index and partial word are cleared. The address and `word_cnt_o` are kept.
- Reset values: `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `done_o` 0, `frame_err_o` 0, `word_cnt_o` 0. The FSM is in IDLE, the synchronizer flops are 1, and the byte index is 0.

## Timing

- `rx_i` falling edge to START entry: 3 cycles (2 synchronizer cycles + 1 IDLE detection cycle).
- Data bit k is sampled CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after START entry.
- The stop bit is sampled CLKS_PER_BIT cycles after bit 7.
- Byte-valid strobe: in the cycle after the stop sample.
- 4th-byte strobe to `mem_we_o`: 1 cycle.
- `mem_addr_o` and `mem_wdata_o` are stable while `mem_we_o` = 1. The address increments in the cycle after the strobe.
- `done_o` rises 1 cycle after the END_WORD match, or in the same cycle as the final-address write strobe.
- Reset is sampled on the `wb_clk_i` rising edge and overrides all activity, including a write in progress: `mem_we_o` is 0 in the cycle after reset is sampled.
- Back-to-back frames: the next start bit is accepted in the first IDLE cycle after STOP.

## Test plan

- Four frames 0x69, 0xAF, 0x1F, 0x42 at CLKS_PER_BIT=16 -> a single `mem_we_o` pulse with addr 0 and data 0x421FAF69; `word_cnt_o` = 1.
- Words 0x421FAF69, 0xC05FDF3C, then 0x00000FFF -> writes to addr 0 and 1 only; `done_o` = 1; further frames produce no writes.
- A 4-cycle low glitch on `rx_i` (CLKS_PER_BIT=16) -> no byte, no write, FSM returns to IDLE, `frame_err_o` = 0.
- Byte 0x69, then a frame with stop bit = 0, then bytes 0x69, 0xAF, 0x1F, 0x42 -> `frame_err_o` = 1; one write of 0x421FAF69 at addr 0.
- ADDR_W=2 with 5 non-end words -> 4 writes at addr 0–3, `done_o` = 1 after the addr-3 write, 5th word ignored, `word_cnt_o` = 4.
- `wb_rst_i` asserted during DATA of the 3rd byte, then a full word sent -> all outputs 0 after reset; the next word is written at addr 0.
